uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 112 +++++++++++
 tb/tb_uart_tx_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO that feeds a UART transmitter through a start/ready handshake
// Macro UART_TXQ_STICKY_OVF_EN: overflow latches until reset instead of pulsing once per rejected push.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  input  logic          uart_tx_rdy,
  output logic          uart_tx_start,
  output logic [7:0]    uart_data,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          tx_start_q, tx_start_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, reject;

  // Acceptance looks only at the registered full flag, so a pop on the same
  // edge never frees a slot for a simultaneous push.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign push   = wr_en && !full;
  assign reject = wr_en && full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && uart_tx_rdy) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!uart_tx_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (uart_tx_rdy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Registered start strobe: high exactly while the FSM sits in WAIT_BUSY.
    tx_start_d = (state_d == WAIT_BUSY);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    data_d = pop ? mem_q[rd_ptr_q] : data_q;
`ifdef UART_TXQ_STICKY_OVF_EN
    ovf_d = ovf_q | reject;
`else
    ovf_d = reject;
`endif
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= 8'h00;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
    end
  end

  assign count         = count_q;
  assign uart_tx_start = tx_start_q;
  assign uart_data     = data_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue with a 10-cycle busy UART model
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TXQ_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          uart_tx_rdy;
  logic          uart_tx_start;
  logic [7:0]    uart_data;
  logic          overflow;

  uart_tx_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .uart_tx_rdy   (uart_tx_rdy),
    .uart_tx_start (uart_tx_start),
    .uart_data     (uart_data),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // UART model: a start seen while idle makes it busy for 10 cycles.
  logic force_busy;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (uart_tx_start && uart_tx_rdy) busy_cnt <= 10;
  end
  assign uart_tx_rdy = !force_busy && (busy_cnt == 0);

  typedef struct {
    logic          wr;
    logic [7:0]    data;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          ovf;
  } vec_t;

  vec_t       vecs [DEPTH+2];
  int         n_checks = 0;
  int         n_fails  = 0;
  int         cyc      = 0;
  logic [7:0] exp_q [$];
  int         rise_cyc [$];
  logic       prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fails++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Every cycle passes through here; each new start strobe is scored against the queue.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (uart_tx_start && !prev_start) begin
      rise_cyc.push_back(cyc);
      if (exp_q.size() == 0) fail_now("unexpected_start", $sformatf("uart_data=%0h with no byte pending", uart_data));
      else check("tx_byte", uart_data, exp_q.pop_front());
    end
    prev_start = uart_tx_start;
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    if (accept) exp_q.push_back(d);
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0;
    for (int i = 0; i < 600 && quiet < 3; i++) begin
      tick();
      quiet = (uart_tx_rdy && !uart_tx_start && empty) ? quiet + 1 : 0;
    end
    if (quiet < 3) fail_now(name, "queue did not go quiet within 600 cycles");
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) fail_now(name, $sformatf("%0d bytes never sent", exp_q.size()));
    wait_quiet(name);
  endtask

  initial begin
    for (int i = 0; i <= DEPTH; i++) begin
      vecs[i].wr    = 1'b1;
      vecs[i].data  = 8'h10 + 8'(i);
      vecs[i].acc   = (i < DEPTH);
      vecs[i].cnt   = (i < DEPTH) ? CW'(i + 1) : CW'(DEPTH);
      vecs[i].full  = (i + 1 >= DEPTH);
      vecs[i].empty = 1'b0;
      vecs[i].ovf   = (i == DEPTH);
    end
    vecs[DEPTH+1] = '{wr: 1'b0, data: 8'h00, acc: 1'b0, cnt: CW'(DEPTH),
                      full: 1'b1, empty: 1'b0, ovf: STICKY};

    // Reset, with a push held high to show reset wins.
    force_busy = 1'b0;
    reset      = 1'b1;
    wr_en      = 1'b1;
    wr_data    = 8'hFF;
    tick();
    tick();
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_tx_start", uart_tx_start, 0);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    wr_en = 1'b0;
    tick();

    // Single byte latency.
    push(8'h55, 1'b1);
    wr_en = 1'b0;
    check("lat_count_n", count, 1);
    check("lat_empty_n", empty, 0);
    tick();
    check("lat_count_n1", count, 0);
    check("lat_data_n1", uart_data, 8'h55);
    check("lat_start_n1", uart_tx_start, 0);
    tick();
    check("lat_start_n2", uart_tx_start, 1);
    wait_drain("lat_drain");

    // Three bytes back-to-back: 14-cycle frame period means one IDLE cycle.
    rise_cyc.delete();
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    push(8'hA3, 1'b1);
    wr_en = 1'b0;
    for (int i = 0; i < 200 && rise_cyc.size() < 3; i++) tick();
    if (rise_cyc.size() < 3) fail_now("b2b_frames", $sformatf("only %0d starts seen", rise_cyc.size()));
    else begin
      check("b2b_gap1", rise_cyc[1] - rise_cyc[0], 14);
      check("b2b_gap2", rise_cyc[2] - rise_cyc[1], 14);
    end
    wait_drain("b2b_drain");

    // Fill past full with the UART held busy.
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].data;
      tick();
      if (vecs[i].wr && vecs[i].acc) exp_q.push_back(vecs[i].data);
      check($sformatf("fill%0d_count", i), count, vecs[i].cnt);
      check($sformatf("fill%0d_full", i), full, vecs[i].full);
      check($sformatf("fill%0d_empty", i), empty, vecs[i].empty);
      check($sformatf("fill%0d_ovf", i), overflow, vecs[i].ovf);
    end

    // Pop and push of 8'h3C on the same edge while full: push rejected.
    force_busy = 1'b0;
    wr_en      = 1'b1;
    wr_data    = 8'h3C;
    tick();
    check("pp_count", count, DEPTH - 1);
    check("pp_full", full, 0);
    check("pp_ovf", overflow, 1);
    tick();
    exp_q.push_back(8'h3C);
    wr_en = 1'b0;
    check("pp_retry_count", count, DEPTH);
    check("pp_retry_full", full, 1);
    check("pp_retry_ovf", overflow, STICKY);
    wait_drain("pp_drain");

    // 40 random bytes in bursts of 8 so both pointers wrap.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) push(8'($urandom_range(0, 255)), 1'b1);
      wr_en = 1'b0;
      wait_drain($sformatf("wrap_drain%0d", r));
    end
    check("wrap_count", count, 0);
    check("wrap_empty", empty, 1);

    // Reset while in WAIT_BUSY with three bytes still queued.
    push(8'hB1, 1'b1);
    push(8'hB2, 1'b1);
    push(8'hB3, 1'b1);
    push(8'hB4, 1'b1);
    wr_en = 1'b0;
    check("mid_start_pre", uart_tx_start, 1);
    check("mid_count_pre", count, 3);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("mid_start", uart_tx_start, 0);
    check("mid_empty", empty, 1);
    check("mid_count", count, 0);
    check("mid_ovf", overflow, 0);
    check("mid_data", uart_data, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("mid_after_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
